// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and the default data width.
package dmem_arb_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int HOLD_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Two-way grant picker. pointer holds the last winner, so the other requester is favoured on a tie.
module arb_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       pointer,
  output logic [1:0] grant
);

  assign grant[0] = req0 & (~req1 | pointer);
  assign grant[1] = req1 & (~req0 | ~pointer);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory, with bounded lock ownership.
// Define RR_ARB_EN for round-robin contention; otherwise requester 0 has fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        pick;
  logic              ptr;
  logic              lock_granted;
  logic              rd_granted;

`ifdef RR_ARB_EN
  logic ptr_q;
  assign ptr = ptr_q;
`else
  assign ptr = 1'b1;
`endif

  arb_pick u_pick (
    .req0    (req0),
    .req1    (req1),
    .pointer (ptr),
    .grant   (pick)
  );

  // Grants are suppressed during reset so no memory write can slip through.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          gnt0 = pick[0];
          gnt1 = pick[1];
        end
        OWN0:    gnt0 = req0;
        OWN1:    gnt1 = req1;
        default: ;
      endcase
    end
  end

  assign mem_a  = gnt1 ? addr1 : addr0;
  assign mem_wd = gnt1 ? wdata1 : wdata0;
  assign mem_we = (gnt0 & we0) | (gnt1 & we1);

  assign lock_granted = (gnt0 & lock0) | (gnt1 & lock1);
  assign rd_granted   = (gnt0 & ~we0) | (gnt1 & ~we1);
  assign hold_inc     = hold_q + 1'b1;

  // Any cycle that is not a locked grant below the hold limit lands in IDLE with a cleared counter.
  always_comb begin
    state_d = IDLE;
    hold_d  = '0;
    if (lock_granted && (hold_inc != HOLD_W'(MAX_HOLD))) begin
      state_d = gnt0 ? OWN0 : OWN1;
      hold_d  = hold_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
`ifdef RR_ARB_EN
      ptr_q     <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      if (rd_granted) rdata_q <= mem_rd;
`ifdef RR_ARB_EN
      if (gnt0)      ptr_q <= 1'b0;
      else if (gnt1) ptr_q <= 1'b1;
`endif
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-cycle behaviour plus a mid-lock reset sequence.
module tb_dmem_arbiter;

`ifdef RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  // Word-addressed memory model: combinational read, write on the clock edge.
  logic [31:0] mem [0:63];
  bit          preloaded = 1'b0;
  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[25]   <= 32'h19;
      preloaded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  typedef struct {
    logic        rst, r0, r1, l0, l1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic        eg0, eg1, emwe;
    logic [31:0] ema, emwd;
    logic        erv0, erv1;
    logic [31:0] erd;
  } vec_t;

  function automatic vec_t v(
    logic rst, logic r0, logic r1, logic l0, logic l1, logic w0, logic w1,
    logic [31:0] a0, logic [31:0] a1, logic [31:0] d0, logic [31:0] d1,
    logic eg0, logic eg1, logic emwe, logic [31:0] ema, logic [31:0] emwd,
    logic erv0, logic erv1, logic [31:0] erd);
    vec_t t;
    t.rst = rst; t.r0 = r0; t.r1 = r1; t.l0 = l0; t.l1 = l1; t.w0 = w0; t.w1 = w1;
    t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.eg0 = eg0; t.eg1 = eg1; t.emwe = emwe; t.ema = ema; t.emwd = emwd;
    t.erv0 = erv0; t.erv1 = erv1; t.erd = erd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic r0, input logic r1, input logic l0,
                       input logic l1, input logic w0, input logic w1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    reset = rst; req0 = r0; req1 = r1; lock0 = l0; lock1 = l1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  vec_t        vecs [23];
  logic [31:0] rd_c;

  initial begin
    rd_c = RR ? 32'h7 : 32'h19;
    // single read, then write/read-back of address 96
    vecs[0]  = v(0,1,0,0,0,0,0, 100,0,0,0,        1,0,0,100,0,        0,0,32'h0);
    vecs[1]  = v(0,0,0,0,0,0,0, 0,0,0,0,          0,0,0,0,0,          1,0,32'h19);
    vecs[2]  = v(0,0,0,0,0,0,0, 0,0,0,0,          0,0,0,0,0,          0,0,32'h19);
    vecs[3]  = v(0,0,1,0,0,0,1, 0,96,0,7,         0,1,1,96,7,         0,0,32'h19);
    vecs[4]  = v(0,0,0,0,0,0,0, 0,0,0,0,          0,0,0,0,0,          0,0,32'h19);
    vecs[5]  = v(0,0,1,0,0,0,0, 0,96,0,0,         0,1,0,96,0,         0,0,32'h19);
    vecs[6]  = v(0,0,0,0,0,0,0, 0,0,0,0,          0,0,0,0,0,          0,1,32'h7);
    // reset, then four contended reads
    vecs[7]  = v(1,0,0,0,0,0,0, 0,0,0,0,          0,0,0,0,0,          0,0,32'h7);
    vecs[8]  = v(0,1,1,0,0,0,0, 100,96,0,0,       1,0,0,100,0,        0,0,32'h0);
    vecs[9]  = v(0,1,1,0,0,0,0, 100,96,0,0,       !RR,RR,0,RR?96:100,0, 1,0,32'h19);
    vecs[10] = v(0,1,1,0,0,0,0, 100,96,0,0,       1,0,0,100,0,        !RR,RR,rd_c);
    vecs[11] = v(0,1,1,0,0,0,0, 100,96,0,0,       !RR,RR,0,RR?96:100,0, 1,0,32'h19);
    vecs[12] = v(0,0,0,0,0,0,0, 0,0,0,0,          0,0,0,0,0,          !RR,RR,rd_c);
    // requester 1 locks for MAX_HOLD grants while requester 0 waits
    vecs[13] = v(0,0,1,0,1,0,1, 100,104,0,32'h55, 0,1,1,104,32'h55,   0,0,rd_c);
    vecs[14] = v(0,1,1,0,1,0,1, 100,104,0,32'h55, 0,1,1,104,32'h55,   0,0,rd_c);
    vecs[15] = v(0,1,1,0,1,0,1, 100,104,0,32'h55, 0,1,1,104,32'h55,   0,0,rd_c);
    vecs[16] = v(0,1,1,0,1,0,1, 100,104,0,32'h55, 0,1,1,104,32'h55,   0,0,rd_c);
    vecs[17] = v(0,1,1,0,1,0,1, 100,104,0,32'h55, 1,0,0,100,0,        0,0,rd_c);
    vecs[18] = v(0,0,0,0,0,0,0, 0,0,0,0,          0,0,0,0,0,          1,0,32'h19);
    // OWN0 released by dropping req0
    vecs[19] = v(0,1,0,1,0,0,0, 100,0,0,0,        1,0,0,100,0,        0,0,32'h19);
    vecs[20] = v(0,0,1,0,0,0,0, 0,104,0,0,        0,0,0,0,0,          1,0,32'h19);
    vecs[21] = v(0,0,1,0,0,0,0, 0,104,0,0,        0,1,0,104,0,        0,0,32'h19);
    vecs[22] = v(0,0,0,0,0,0,0, 0,0,0,0,          0,0,0,0,0,          0,1,32'h55);

    // reset with both requesting: nothing may be granted or written
    drive(1,1,1,0,0,1,1, 100,96,32'hAA,32'hBB);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_gnt0", {31'b0, gnt0}, 32'h0);
    chk("rst_gnt1", {31'b0, gnt1}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_rvalid0", {31'b0, rvalid0}, 32'h0);
    chk("rst_rvalid1", {31'b0, rvalid1}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rst, vecs[i].r0, vecs[i].r1, vecs[i].l0, vecs[i].l1, vecs[i].w0,
            vecs[i].w1, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i), {31'b0, gnt0}, {31'b0, vecs[i].eg0});
      chk($sformatf("v%0d_gnt1", i), {31'b0, gnt1}, {31'b0, vecs[i].eg1});
      chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].emwe});
      if (vecs[i].eg0 || vecs[i].eg1) chk($sformatf("v%0d_mem_a", i), mem_a, vecs[i].ema);
      if (vecs[i].emwe) chk($sformatf("v%0d_mem_wd", i), mem_wd, vecs[i].emwd);
      chk($sformatf("v%0d_rvalid0", i), {31'b0, rvalid0}, {31'b0, vecs[i].erv0});
      chk($sformatf("v%0d_rvalid1", i), {31'b0, rvalid1}, {31'b0, vecs[i].erv1});
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].erd);
      @(posedge clk); #1;
    end

    // Mid-lock reset: enter OWN1 with a write, reset for one cycle, then both request.
    drive(0,0,1,0,1,0,1, 0,108,0,32'h66);
    @(negedge clk);
    chk("ml_own_gnt1", {31'b0, gnt1}, 32'h1);
    @(posedge clk); #1;
    drive(1,1,1,0,1,1,1, 112,112,32'h77,32'h77);
    @(negedge clk);
    chk("ml_rst_gnt0", {31'b0, gnt0}, 32'h0);
    chk("ml_rst_gnt1", {31'b0, gnt1}, 32'h0);
    chk("ml_rst_mem_we", {31'b0, mem_we}, 32'h0);
    @(posedge clk); #1;
    drive(0,1,1,0,1,0,0, 108,108,0,0);
    @(negedge clk);
    chk("ml_after_gnt0", {31'b0, gnt0}, 32'h1);
    chk("ml_after_gnt1", {31'b0, gnt1}, 32'h0);
    chk("ml_after_rvalid0", {31'b0, rvalid0}, 32'h0);
    chk("ml_after_rvalid1", {31'b0, rvalid1}, 32'h0);
    chk("ml_after_rdata", rdata, 32'h0);
    chk("ml_no_write_in_reset", mem[28], 32'h0);
    @(posedge clk); #1;
    drive(0,0,0,0,0,0,0, 0,0,0,0);
    @(negedge clk);
    chk("ml_read_rvalid0", {31'b0, rvalid0}, 32'h1);
    chk("ml_read_rdata", rdata, 32'h66);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
